// File: rtl/hptdc_readout_ctrl.sv
// Readout sequencer for one HPTDC chip: trigger -> token -> hit pulls -> FIFO writes -> trailer.
// Token, get_data, busy and done decode from state; FIFO and error outputs are flops.
module hptdc_readout_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int MAX_WORDS      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trig_in,
  output logic        hptdc_token_in,
  input  logic        hptdc_token_out,
  output logic        hptdc_get_data,
  input  logic        hptdc_data_ready,
  input  logic [31:0] hptdc_data,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  input  logic        fifo_full,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [11:0] event_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]   W_MAX  = 12'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_REQ, S_PUSH, S_RELEASE, S_TRAILER, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [11:0] word_cnt_q, word_cnt_d;
  logic [11:0] event_cnt_q, event_cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        to_flag_q, to_flag_d;
  logic        tr_flag_q, tr_flag_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    word_cnt_d    = word_cnt_q;
    event_cnt_d   = event_cnt_q;
    hold_d        = hold_q;
    to_flag_d     = to_flag_q;
    tr_flag_d     = tr_flag_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && trig_in) begin
          state_d    = S_START;
          word_cnt_d = '0;
          timer_d    = '0;
          to_flag_d  = 1'b0;
          tr_flag_d  = 1'b0;
        end
      end
      S_START: begin
        state_d = S_REQ;
        timer_d = '0;
      end
      S_REQ: begin
        // Data beats token, token beats timeout when they coincide.
        if (hptdc_data_ready) begin
          hold_d  = hptdc_data;
          state_d = S_PUSH;
        end else if (hptdc_token_out) begin
          state_d = S_TRAILER;
        end else if (timer_q == T_LAST) begin
          to_flag_d     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_TRAILER;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PUSH: begin
        if (!fifo_full) begin
          wr_en_d    = 1'b1;
          wr_data_d  = hold_q;
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!hptdc_data_ready) begin
          if (word_cnt_q == W_MAX) begin
            tr_flag_d = 1'b1;
            state_d   = S_TRAILER;
          end else begin
            timer_d = '0;
            state_d = S_REQ;
          end
        end
      end
      S_TRAILER: begin
        if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = {4'hA, to_flag_q, tr_flag_q, 2'b00, event_cnt_q, word_cnt_q};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        event_cnt_d = event_cnt_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      word_cnt_q    <= '0;
      event_cnt_q   <= '0;
      hold_q        <= '0;
      to_flag_q     <= 1'b0;
      tr_flag_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      word_cnt_q    <= word_cnt_d;
      event_cnt_q   <= event_cnt_d;
      hold_q        <= hold_d;
      to_flag_q     <= to_flag_d;
      tr_flag_q     <= tr_flag_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign hptdc_token_in = (state_q == S_START);
  assign hptdc_get_data = (state_q == S_REQ);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign timeout_err    = timeout_err_q;
  assign event_cnt      = event_cnt_q;

endmodule

// File: tb/tb_hptdc_readout_ctrl.sv
// Bench for hptdc_readout_ctrl: two instances (deep and 2-word event limit) driven by an
// emulated chip; expected FIFO words come from an event-level model through a scoreboard.
module tb_hptdc_readout_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic full;
  logic        trig[2], tok_in[2], tok_out[2], get[2], dr[2];
  logic [31:0] hd[2], wd[2];
  logic        wr[2], busy[2], done[2], terr[2];
  logic [11:0] ecnt[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gd
    hptdc_readout_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(g == 0 ? 256 : 2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .trig_in(trig[g]),
      .hptdc_token_in(tok_in[g]), .hptdc_token_out(tok_out[g]),
      .hptdc_get_data(get[g]), .hptdc_data_ready(dr[g]), .hptdc_data(hd[g]),
      .fifo_wr_en(wr[g]), .fifo_wr_data(wd[g]), .fifo_full(full),
      .busy(busy[g]), .done(done[g]), .timeout_err(terr[g]), .event_cnt(ecnt[g])
    );
  end

  typedef struct { int g; logic [31:0] w; } exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [31:0] hit_mem[2][16];
  int   n_hits[2], hit_idx[2], dly[2];
  bit   silent[2];
  bit   fast = 0, hold_dr = 0, rand_full = 0, full_force = 0;
  int   to_seen[2], done_seen[2], terr_cyc[2], done_cyc[2];
  int   d0_s[2], to0_s[2], tok_cyc;
  logic [11:0] ev_model[2];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int maxw(int g);
    return (g == 0) ? 256 : 2;
  endfunction

  // Event-level reference: which hits reach the FIFO and what the trailer says.
  function automatic bit expect_event(int g, int n, bit sil);
    int wc = (n < maxw(g)) ? n : maxw(g);
    bit tr = (n >= maxw(g));
    bit to = !tr && sil;
    logic [11:0] wc12 = 12'(wc);
    for (int i = 0; i < wc; i++) expq.push_back('{g: g, w: hit_mem[g][i]});
    expq.push_back('{g: g, w: {4'hA, to, tr, 2'b00, ev_model[g], wc12}});
    return to;
  endfunction

  always @(posedge clk) cyc++;

  // Chip emulation and FIFO backpressure, driven away from the active edge.
  always @(negedge clk) begin
    full = full_force || (rand_full && ($urandom_range(0, 3) == 0));
    for (int g = 0; g < 2; g++) begin
      if (dr[g]) begin
        if (!get[g] && !hold_dr && ($urandom_range(0, 1) == 0)) dr[g] = 1'b0;
      end else begin
        hd[g] = $urandom;
        if (!get[g]) begin
          dly[g]     = fast ? 0 : $urandom_range(0, 3);
          tok_out[g] = !fast && ($urandom_range(0, 3) == 0);
        end else if (dly[g] > 0) begin
          dly[g]--;
          tok_out[g] = 1'b0;
        end else if (hit_idx[g] < n_hits[g]) begin
          dr[g]      = 1'b1;
          hd[g]      = hit_mem[g][hit_idx[g]];
          tok_out[g] = 1'b0;
          hit_idx[g]++;
        end else begin
          tok_out[g] = !silent[g];
        end
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr[g]) begin
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_fifo_write", wd[g], 32'h0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk(e.g == g && wd[g] === e.w, "fifo_word", wd[g], e.w);
        end
      end
      if (terr[g]) begin to_seen[g]++; terr_cyc[g] = cyc; end
      if (done[g]) begin done_seen[g]++; done_cyc[g] = cyc; end
    end
  end

  task automatic start_event(input int g, input int n, input bit sil, input bit preset,
                             input bit dbl, input bit drop_en);
    bit unused_to;
    if (!preset) for (int i = 0; i < n; i++) hit_mem[g][i] = $urandom;
    n_hits[g] = n; hit_idx[g] = 0; silent[g] = sil;
    unused_to = expect_event(g, n, sil);
    d0_s[g] = done_seen[g]; to0_s[g] = to_seen[g];
    trig[g] = 1'b1;
    @(posedge clk); #1;
    trig[g] = 1'b0;
    tok_cyc = cyc;
    chk(tok_in[g] && busy[g], "token_after_trigger", {30'd0, tok_in[g], busy[g]}, 32'h3);
    if (dbl) trig[g] = 1'b1;
    @(posedge clk); #1;
    trig[g] = 1'b0;
    chk(get[g] && !tok_in[g], "get_after_token", {30'd0, get[g], tok_in[g]}, 32'h2);
    if (drop_en) enable = 1'b0;
  endtask

  task automatic finish_event(input int g, input int n, input bit sil);
    int wc = (n < maxw(g)) ? n : maxw(g);
    int exp_to = ((n < maxw(g)) && sil) ? 1 : 0;
    for (int i = 0; i < 400 && done_seen[g] == d0_s[g]; i++) begin
      @(posedge clk); #1;
    end
    chk(done_seen[g] == d0_s[g] + 1, "done_pulse", done_seen[g] - d0_s[g], 1);
    enable = 1'b1;
    @(posedge clk); #1;
    ev_model[g] = ev_model[g] + 12'd1;
    chk(ecnt[g] == ev_model[g], "event_cnt", {20'd0, ecnt[g]}, {20'd0, ev_model[g]});
    chk(to_seen[g] - to0_s[g] == exp_to, "timeout_pulses", to_seen[g] - to0_s[g], exp_to);
    chk(expq.size() == 0, "words_pending", expq.size(), 0);
    chk(hit_idx[g] == wc, "chip_words_taken", hit_idx[g], wc);
    chk(!busy[g], "idle_after_done", {31'd0, busy[g]}, 0);
    if (fast && n == 0 && !sil)
      chk(done_cyc[g] - tok_cyc == 3, "min_event_latency", done_cyc[g] - tok_cyc, 3);
    if (n == 0 && sil)
      chk(terr_cyc[g] - tok_cyc == TO + 1, "timeout_latency", terr_cyc[g] - tok_cyc - 1, TO);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; enable = 1'b0; full = 1'b0;
    for (int g = 0; g < 2; g++) begin
      trig[g] = 0; tok_out[g] = 0; dr[g] = 0; hd[g] = '0;
      n_hits[g] = 0; hit_idx[g] = 0; dly[g] = 0; silent[g] = 0;
      to_seen[g] = 0; done_seen[g] = 0; terr_cyc[g] = 0; done_cyc[g] = 0;
      ev_model[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++)
      chk({tok_in[g], get[g], wr[g], busy[g], done[g], terr[g]} == 6'd0 && wd[g] == 0 && ecnt[g] == 0,
          "reset_outputs", {tok_in[g], get[g], wr[g], busy[g], done[g], terr[g]}, 0);

    // Trigger while disabled must be ignored.
    trig[0] = 1'b1;
    @(posedge clk); #1;
    trig[0] = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      if (tok_in[0] || busy[0]) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk(quiet, "disabled_trigger_ignored", {31'd0, quiet}, 1);
    enable = 1'b1;

    hit_mem[0][0] = 32'h11111111; hit_mem[0][1] = 32'h22222222; hit_mem[0][2] = 32'h33333333;
    start_event(0, 3, 0, 1, 0, 0);
    finish_event(0, 3, 0);

    start_event(1, 5, 0, 0, 0, 0);
    finish_event(1, 5, 0);

    // Backpressure held for 10 cycles while a hit waits in the hold register.
    full_force = 1'b1;
    start_event(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 200 && get[0]; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk(!wr[0] && !get[0], "stalled_push", {30'd0, wr[0], get[0]}, 0);
      @(posedge clk); #1;
    end
    full_force = 1'b0;
    @(posedge clk); #1;
    chk(wr[0], "write_after_release", {31'd0, wr[0]}, 1);
    finish_event(0, 1, 0);

    fast = 1'b1;
    start_event(0, 0, 0, 0, 0, 0);
    finish_event(0, 0, 0);
    fast = 1'b0;

    rand_full = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int g = ($urandom_range(0, 3) == 0) ? 1 : 0;
      int n = $urandom_range(0, 6);
      bit sil = ($urandom_range(0, 3) == 0);
      start_event(g, n, sil, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      finish_event(g, n, sil);
    end
    rand_full = 1'b0;

    // Asynchronous reset while the DUT waits in RELEASE.
    hold_dr = 1'b1;
    start_event(0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 100 && !wr[0]; i++) begin
      @(posedge clk); #1;
    end
    chk(wr[0], "first_write_before_reset", {31'd0, wr[0]}, 1);
    #2 rst = 1'b1;
    #1;
    chk({tok_in[0], get[0], wr[0], busy[0], done[0], terr[0]} == 6'd0 && wd[0] == 0 && ecnt[0] == 0,
        "async_reset_clear", {tok_in[0], get[0], wr[0], busy[0], done[0], terr[0]}, 0);
    expq.delete();
    hold_dr = 1'b0;
    ev_model[0] = '0; ev_model[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    start_event(0, 0, 1, 0, 0, 0);
    finish_event(0, 0, 1);

    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 5);
      start_event(0, n, 0, 0, 1, 0);
      finish_event(0, n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
